// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-of-3 mid-bit voting, optional parity, 1-2 stop bits,
// and a single-word holding register drained through a valid/ready handshake.
module uart_rx_param #(
    parameter int CLK_DIV    = 2,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [2:0]           state_dbg
);
    // valid/ready: a word moves on any rising clk edge with both high; until then valid
    // stays high and data/flags stay stable. ready while valid is low is ignored.
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] MID_LO   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] MID      = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] MID_HI   = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rxs_q, rxs_prev_q;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  fe_acc_q, fe_acc_d;
    logic                  last_stop_q, last_stop_d;
    logic                  commit_q, commit_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                  tick, vote, vote_now, bit_done, par_calc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            div_q       <= '0;
            tick_q      <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            shift_q     <= '0;
            par_q       <= 1'b0;
            fe_acc_q    <= 1'b0;
            last_stop_q <= 1'b1;
            commit_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            div_q       <= div_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            fe_acc_q    <= fe_acc_d;
            last_stop_q <= last_stop_d;
            commit_q    <= commit_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    // Ticks are counted from the start edge, so tick OVERSAMPLE-1 closes each bit.
    always_comb begin
        tick     = (state_q != S_IDLE) && (div_q == DIV_MAX);
        vote     = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
        vote_now = tick && (tick_q == MID_HI);
        bit_done = tick && (tick_q == TICK_MAX);

        state_d     = state_q;
        div_d       = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        tick_d      = tick_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        shift_d     = shift_q;
        par_d       = par_q;
        fe_acc_d    = fe_acc_q;
        last_stop_d = last_stop_q;
        commit_d    = 1'b0;

        if (tick) tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
        if (tick && tick_q == MID_LO) s0_d = rxs_q;
        if (tick && tick_q == MID) s1_d = rxs_q;

        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                tick_d = '0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            S_START: begin
                if (vote_now && vote) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    tick_d  = '0;
                end else if (bit_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (vote_now) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (bit_done) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d    = '0;
                        stop_d   = 1'b0;
                        fe_acc_d = 1'b0;
                        state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (vote_now) par_d = vote;
                if (bit_done) begin
                    state_d  = S_STOP;
                    stop_d   = 1'b0;
                    fe_acc_d = 1'b0;
                end
            end
            S_STOP: begin
                if (commit_q) begin
                    state_d = last_stop_q ? S_IDLE : S_WAIT_HIGH;
                    if (last_stop_q) begin
                        div_d  = '0;
                        tick_d = '0;
                    end
                end else begin
                    if (vote_now) begin
                        if (!vote) fe_acc_d = 1'b1;
                        last_stop_d = vote;
                        if (stop_q == STOP_LAST) commit_d = 1'b1;
                    end
                    if (bit_done) stop_d = stop_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    tick_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        par_calc = 1'b0;
        if (PARITY == 1) par_calc = ^shift_q ^ par_q;
        if (PARITY == 2) par_calc = ~(^shift_q ^ par_q);

        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (commit_q) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                perr_d  = par_calc;
                ferr_d  = fe_acc_q;
                valid_d = 1'b1;
                if (valid_q) ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 receiver and an even-parity two-stop receiver,
// both at CLK_DIV=4, OVERSAMPLE=16, driven with directed frames.
module tb_uart_rx_param;
    localparam int C        = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = C * OS;
    localparam int W        = 10;
    // First clk after rx falls, plus 4*(9*16+10) clks to the line sample of the last
    // stop vote, plus 2 synchroniser clks and 1 commit clk.
    localparam int EXP_LAT  = 620;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1, rx_p = 1'b1;
    logic       ready = 1'b1, ready_p = 1'b1;
    logic [7:0] data, data_p;
    logic       valid, valid_p, parity_err, parity_err_p, frame_err, frame_err_p;
    logic       overrun, overrun_p;
    logic [2:0] state_dbg, state_dbg_p;

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    uart_rx_param #(.CLK_DIV(C), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .state_dbg(state_dbg)
    );

    uart_rx_param #(.CLK_DIV(C), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_p (
        .clk(clk), .reset(reset), .rx(rx_p), .data(data_p), .valid(valid_p), .ready(ready_p),
        .parity_err(parity_err_p), .frame_err(frame_err_p), .overrun(overrun_p),
        .state_dbg(state_dbg_p)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // scoreboard: {parity_err, frame_err, data}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_p_q[$];
    logic [W-1:0] e_m, e_p;

    always @(negedge clk) begin
        if (reset && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL word_8n1: got unexpected 0x%0h, expected none", data);
            end else begin
                e_m = exp_q.pop_front();
                check("word_8n1", {22'd0, parity_err, frame_err, data}, {22'd0, e_m});
            end
        end
        if (reset && valid_p && ready_p) begin
            if (exp_p_q.size() == 0) begin
                checks++;
                $display("FAIL word_8e2: got unexpected 0x%0h, expected none", data_p);
            end else begin
                e_p = exp_p_q.pop_front();
                check("word_8e2", {22'd0, parity_err_p, frame_err_p, data_p}, {22'd0, e_p});
            end
        end
    end

    logic valid_prev = 1'b0;
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    always @(negedge clk) begin
        if (valid && !valid_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        valid_prev <= valid;
    end

    // driver tasks
    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_p = v;
        else rx = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) drive_bit(sel, bits[i]);
        if (sel) rx_p = 1'b1;
        else rx = 1'b1;
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_frame(1'b0, {6'b0, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic send_8e2(input logic [7:0] d, input logic p, input logic s2);
        send_frame(1'b1, {4'b0, s2, 1'b1, p, d, 1'b0}, 12);
    endtask

    int t0, r0;

    initial begin
        idle_clks(3);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_flags", {parity_err, frame_err, overrun}, 0);
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_valid_p", valid_p, 0);
        reset = 1'b1;
        idle_clks(10);

        // 8N1 0xA5 with latency
        exp_q.push_back({2'b00, 8'hA5});
        t0 = cyc;
        send_8n1(8'hA5);
        check("a5_latency", rise_cyc - t0, EXP_LAT);
        idle_clks(BIT_CLKS);

        // even parity, two stop bits
        exp_p_q.push_back({2'b10, 8'h03});
        send_8e2(8'h03, 1'b1, 1'b1);
        idle_clks(BIT_CLKS);
        exp_p_q.push_back({2'b00, 8'h03});
        send_8e2(8'h03, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        exp_p_q.push_back({2'b01, 8'h03});
        send_8e2(8'h03, 1'b0, 1'b0);
        idle_clks(BIT_CLKS);
        check("p_state_idle", state_dbg_p, ST_IDLE);

        // false start
        r0 = rise_cnt;
        rx = 1'b0;
        idle_clks(20);
        rx = 1'b1;
        idle_clks(2 * BIT_CLKS);
        check("glitch_state", state_dbg, ST_IDLE);
        check("glitch_no_valid", rise_cnt - r0, 0);
        exp_q.push_back({2'b00, 8'h5A});
        send_8n1(8'h5A);
        idle_clks(BIT_CLKS);

        // overrun
        ready = 1'b0;
        exp_q.push_back({2'b00, 8'h11});
        send_8n1(8'h11);
        idle_clks(8);
        send_8n1(8'h22);
        idle_clks(8);
        check("ovr_valid", valid, 1);
        check("ovr_data", data, 8'h11);
        check("ovr_flag", overrun, 1);
        ready = 1'b1;
        idle_clks(1);
        ready = 1'b0;
        check("ovr_drain_valid", valid, 0);
        check("ovr_drain_flag", overrun, 0);
        check("ovr_drain_data_hold", data, 8'h11);

        // break: start + 8 zero bits + stop low for 3 bit times
        ready = 1'b1;
        r0 = rise_cnt;
        exp_q.push_back({2'b01, 8'h00});
        for (int i = 0; i < 12; i++) drive_bit(1'b0, 1'b0);
        check("break_wait_high", state_dbg, ST_WAIT_HIGH);
        rx = 1'b1;
        idle_clks(BIT_CLKS);
        check("break_one_commit", rise_cnt - r0, 1);
        check("break_recovered", state_dbg, ST_IDLE);

        // 0x7E left held for the reset test
        ready = 1'b0;
        send_8n1(8'h7E);
        idle_clks(BIT_CLKS);
        check("h7e_valid", valid, 1);
        check("h7e_data", data, 8'h7E);
        check("h7e_flags", {parity_err, frame_err, overrun}, 0);

        // reset during data bit 4 of 0xF0
        r0 = rise_cnt;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
        rx = 1'b1;
        idle_clks(BIT_CLKS / 2);
        #2 reset = 1'b0;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);
        check("midrst_flags", {parity_err, frame_err, overrun}, 0);
        check("midrst_state", state_dbg, ST_IDLE);
        idle_clks(3);
        reset = 1'b1;
        idle_clks(5 * BIT_CLKS);
        check("midrst_no_valid", rise_cnt - r0, 0);
        ready = 1'b1;
        exp_q.push_back({2'b00, 8'hC3});
        send_8n1(8'hC3);
        idle_clks(2 * BIT_CLKS);

        check("exp_q_drained", exp_q.size(), 0);
        check("exp_p_q_drained", exp_p_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
